// File: rtl/gate_reduce_pipe_if.sv
// Bus bundle for gate_reduce_pipe: input beat channel and reduced-output channel.
// A beat moves on a channel in any cycle where valid && ready; the sender must hold
// valid and its payload steady until that cycle, and ready may depend on valid.
interface gate_reduce_pipe_if #(
    parameter int NCH = 4,
    parameter int W   = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [NCH*W-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [NCH-1:0]   out_bits;
    logic [NCH-1:0]   out_trunc;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_bits, out_trunc
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_bits, out_trunc
    );
endinterface

// File: rtl/gate_reduce_pipe.sv
// Two-stage valid/ready pipeline reducing NCH packed W-bit channels to one bit each,
// with per-channel truncation flags and a saturating count of truncating output beats.
module gate_reduce_pipe #(
    parameter int NCH   = 4,
    parameter int W     = 12,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    gate_reduce_pipe_if.slave bus,
    input  logic              sticky_clr,
    output logic [CNT_W-1:0]  trunc_count
);
    typedef enum logic [1:0] {
        MODE_OR     = 2'd0,
        MODE_NAND   = 2'd1,
        MODE_STICKY = 2'd2,
        MODE_XOR    = 2'd3
    } mode_e;

    logic             s1_valid_q, s1_valid_d;
    logic [NCH*W-1:0] s1_data_q, s1_data_d;
    mode_e            s1_mode_q, s1_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [NCH-1:0]   out_bits_q, out_bits_d;
    logic [NCH-1:0]   out_trunc_q, out_trunc_d;
    logic [NCH-1:0]   st_q, st_d;
    logic [CNT_W-1:0] trunc_count_q, trunc_count_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_ready_int;
    logic             in_fire;
    logic [NCH-1:0]   res;
    logic [NCH-1:0]   trunc;

    always_comb begin
        s2_adv       = !out_valid_q || bus.out_ready;
        s1_adv       = s1_valid_q && s2_adv;
        in_ready_int = !s1_valid_q || s2_adv;
        in_fire      = bus.in_valid && in_ready_int;
    end

    // Reduction of the stage-1 beat; sticky mode folds in the pre-edge sticky state.
    always_comb begin
        res   = '0;
        trunc = '0;
        for (int c = 0; c < NCH; c++) begin
            case (s1_mode_q)
                MODE_OR:     res[c] = |s1_data_q[c*W +: W];
                MODE_NAND:   res[c] = ~&s1_data_q[c*W +: W];
                MODE_STICKY: res[c] = (|s1_data_q[c*W +: W]) | st_q[c];
                default:     res[c] = ^s1_data_q[c*W +: W];
            endcase
            trunc[c] = |s1_data_q[c*W+1 +: W-1];
        end
    end

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_data_d     = s1_data_q;
        s1_mode_d     = s1_mode_q;
        out_valid_d   = out_valid_q;
        out_bits_d    = out_bits_q;
        out_trunc_d   = out_trunc_q;
        st_d          = st_q;
        trunc_count_d = trunc_count_q;

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = bus.in_data;
            s1_mode_d  = mode_e'(bus.in_mode);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
        end
        if (s1_adv) begin
            out_bits_d  = res;
            out_trunc_d = trunc;
        end

        // Clear wins over a same-cycle sticky update.
        if (sticky_clr) begin
            st_d = '0;
        end else if (s1_adv && s1_mode_q == MODE_STICKY) begin
            st_d = res;
        end

        if (out_valid_q && bus.out_ready && (|out_trunc_q) && (trunc_count_q != '1)) begin
            trunc_count_d = trunc_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_mode_q     <= MODE_OR;
            out_valid_q   <= 1'b0;
            out_bits_q    <= '0;
            out_trunc_q   <= '0;
            st_q          <= '0;
            trunc_count_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_mode_q     <= s1_mode_d;
            out_valid_q   <= out_valid_d;
            out_bits_q    <= out_bits_d;
            out_trunc_q   <= out_trunc_d;
            st_q          <= st_d;
            trunc_count_q <= trunc_count_d;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.out_trunc = out_trunc_q;
    assign trunc_count   = trunc_count_q;
endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Directed bench for gate_reduce_pipe: vector table plus sticky, stall, saturation
// and asynchronous-reset sequences.
module tb_gate_reduce_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sticky_clr0 = 1'b0;
    logic        sticky_clr1 = 1'b0;
    logic [15:0] trunc_count0;
    logic [1:0]  trunc_count1;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    gate_reduce_pipe_if #(.NCH(4), .W(12)) if0 ();
    gate_reduce_pipe_if #(.NCH(4), .W(12)) if1 ();

    gate_reduce_pipe #(.NCH(4), .W(12), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave),
        .sticky_clr(sticky_clr0), .trunc_count(trunc_count0)
    );

    gate_reduce_pipe #(.NCH(4), .W(12), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .sticky_clr(sticky_clr1), .trunc_count(trunc_count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [47:0] data;
        logic [3:0]  exp_bits;
        logic [3:0]  exp_trunc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference for plain modes (sticky state assumed clear).
    function automatic logic [7:0] model(input logic [47:0] d, input logic [1:0] m);
        logic [3:0]  b;
        logic [3:0]  t;
        logic [11:0] x;
        for (int c = 0; c < 4; c++) begin
            x = d[c*12 +: 12];
            case (m)
                2'd1:    b[c] = (x != 12'hFFF);
                2'd3:    b[c] = ($countones(x) % 2) == 1;
                default: b[c] = (x != 12'h000);
            endcase
            t[c] = (x > 12'h001);
        end
        return {t, b};
    endfunction

    function automatic logic [47:0] beat_data(input int i);
        return {12'(i * 3 + 1), 12'(1 << i), 12'(i * 100), 12'hFFF ^ 12'(i)};
    endfunction

    function automatic logic [1:0] beat_mode(input int i);
        return (i % 3 == 0) ? 2'd0 : ((i % 3 == 1) ? 2'd1 : 2'd3);
    endfunction

    // One isolated beat on if0 with out_ready high; optional sticky_clr while it sits in stage 1.
    task automatic do_beat(input string name, input logic [47:0] d, input logic [1:0] m,
                           input bit clr, output logic [3:0] b, output logic [3:0] t);
        if0.in_valid = 1'b1;
        if0.in_data  = d;
        if0.in_mode  = m;
        check({name, "_in_ready"}, 32'(if0.in_ready), 32'd1);
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        sticky_clr0  = clr;
        check({name, "_valid_n1"}, 32'(if0.out_valid), 32'd0);
        @(posedge clk); #1;
        sticky_clr0 = 1'b0;
        check({name, "_valid_n2"}, 32'(if0.out_valid), 32'd1);
        b = if0.out_bits;
        t = if0.out_trunc;
        @(posedge clk); #1;
        check({name, "_valid_drop"}, 32'(if0.out_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0]  b;
        logic [3:0]  t;
        logic [7:0]  exp_v;
        logic [7:0]  held;
        logic [7:0]  exp_q[$];
        bit          held_v;
        bit          fire_in;
        bit          fire_out;
        int          acc;
        int          cons;
        int          last_cons;
        int          sent;
        int          k;

        vecs[0] = '{2'd0, {12'h000, 12'h001, 12'h800, 12'h000}, 4'b0110, 4'b0010};
        vecs[1] = '{2'd1, {12'h001, 12'h000, 12'hFFE, 12'hFFF}, 4'b1110, 4'b0011};
        vecs[2] = '{2'd3, {12'h003, 12'h001, 12'h7FF, 12'h000}, 4'b0110, 4'b1010};
        vecs[3] = '{2'd0, {12'h000, 12'h000, 12'h000, 12'h000}, 4'b0000, 4'b0000};
        vecs[4] = '{2'd1, {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}, 4'b0000, 4'b1111};
        vecs[5] = '{2'd3, {12'hFFF, 12'h002, 12'h001, 12'h800}, 4'b0111, 4'b1101};
        vecs[6] = '{2'd1, {12'h000, 12'h001, 12'h002, 12'hFFF}, 4'b1110, 4'b0011};

        if0.in_valid = 1'b0; if0.in_data = '0; if0.in_mode = 2'd0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_data = '0; if1.in_mode = 2'd0; if1.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(if0.out_valid), 32'd0);
        check("rst_out_bits", 32'(if0.out_bits), 32'd0);
        check("rst_out_trunc", 32'(if0.out_trunc), 32'd0);
        check("rst_count", 32'(trunc_count0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 7; i++) begin
            do_beat($sformatf("vec%0d", i), vecs[i].data, vecs[i].mode, 1'b0, b, t);
            check($sformatf("vec%0d_bits", i), 32'(b), 32'(vecs[i].exp_bits));
            check($sformatf("vec%0d_trunc", i), 32'(t), 32'(vecs[i].exp_trunc));
            if (vecs[i].exp_trunc != 4'b0000) exp_cnt++;
            check($sformatf("vec%0d_count", i), 32'(trunc_count0), 32'(exp_cnt));
        end

        // Sticky OR with a clear landing on the third beat's stage-2 transfer
        do_beat("sticky_a", 48'h001, 2'd2, 1'b0, b, t);
        check("sticky_a_bits", 32'(b), 32'b0001);
        do_beat("sticky_b", 48'h000, 2'd2, 1'b0, b, t);
        check("sticky_b_bits", 32'(b), 32'b0001);
        do_beat("sticky_c", 48'h000, 2'd2, 1'b1, b, t);
        check("sticky_c_bits", 32'(b), 32'b0001);
        do_beat("sticky_d", 48'h000, 2'd2, 1'b0, b, t);
        check("sticky_d_bits", 32'(b), 32'b0000);
        check("sticky_count", 32'(trunc_count0), 32'(exp_cnt));

        // Back-to-back stream with out_ready low in cycles 3..7
        acc = 0; cons = 0; last_cons = -1; held_v = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && cons < 6; cyc++) begin
            if0.out_ready = !(cyc >= 3 && cyc <= 7);
            if (acc < 6) begin
                if0.in_valid = 1'b1;
                if0.in_data  = beat_data(acc);
                if0.in_mode  = beat_mode(acc);
            end else begin
                if0.in_valid = 1'b0;
            end
            #1;
            check($sformatf("stream_in_ready_c%0d", cyc), 32'(if0.in_ready),
                  32'(!((acc - cons) == 2 && !if0.out_ready)));
            if (held_v) begin
                check($sformatf("stream_hold_valid_c%0d", cyc), 32'(if0.out_valid), 32'd1);
                check($sformatf("stream_hold_data_c%0d", cyc),
                      32'({if0.out_trunc, if0.out_bits}), 32'(held));
            end
            held_v = if0.out_valid && !if0.out_ready;
            held   = {if0.out_trunc, if0.out_bits};
            if (if0.out_valid && if0.out_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : ~{if0.out_trunc, if0.out_bits};
                check($sformatf("stream_beat%0d", cons), 32'({if0.out_trunc, if0.out_bits}), 32'(exp_v));
                if (exp_v[7:4] != 4'b0000) exp_cnt++;
                if (cyc > 8) check($sformatf("stream_rate_c%0d", cyc), 32'(cyc), 32'(last_cons + 1));
                last_cons = cyc;
                cons++;
            end
            if (if0.in_valid && if0.in_ready) begin
                exp_q.push_back(model(if0.in_data, if0.in_mode));
                acc++;
            end
            @(posedge clk); #1;
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        check("stream_consumed", 32'(cons), 32'd6);
        check("stream_count", 32'(trunc_count0), 32'(exp_cnt));

        // Saturating counter on the CNT_W=2 instance
        sent = 0; k = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if1.in_valid = (sent < 5);
            if1.in_data  = {12'h000, 12'h000, 12'h002, 12'h000};
            if1.in_mode  = 2'd0;
            #1;
            fire_in  = if1.in_valid && if1.in_ready;
            fire_out = if1.out_valid && if1.out_ready;
            @(posedge clk); #1;
            if (fire_in) sent++;
            if (fire_out) begin
                k++;
                check($sformatf("sat_count_%0d", k), 32'(trunc_count1), (k > 3) ? 32'd3 : 32'(k));
            end
        end
        if1.in_valid = 1'b0;
        check("sat_beats", 32'(k), 32'd5);

        // Asynchronous reset with both stages full and sticky state set
        if0.out_ready = 1'b0;
        if0.in_valid  = 1'b1;
        if0.in_data   = 48'h001;
        if0.in_mode   = 2'd2;
        @(posedge clk); #1;
        if0.in_data = 48'h000;
        if0.in_mode = 2'd0;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        check("arst_pre_valid", 32'(if0.out_valid), 32'd1);
        check("arst_pre_in_ready", 32'(if0.in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(if0.out_valid), 32'd0);
        check("arst_out_bits", 32'(if0.out_bits), 32'd0);
        check("arst_out_trunc", 32'(if0.out_trunc), 32'd0);
        check("arst_count", 32'(trunc_count0), 32'd0);
        check("arst_in_ready", 32'(if0.in_ready), 32'd1);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        @(posedge clk); #1;
        if0.out_ready = 1'b1;
        do_beat("post_rst", 48'h000, 2'd2, 1'b0, b, t);
        check("post_rst_sticky_bits", 32'(b), 32'b0000);
        check("post_rst_count", 32'(trunc_count0), 32'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
